multiword_add_seq: RTL and testbench
====================================

# multiword_add_seq

Multi-cycle wide-operand adder/subtractor that sits directly upstream of the team's N-bit chunk adder datapath. It accepts two W-bit operands through a valid/ready handshake. It feeds them to a single N-bit adder one chunk per cycle, least-significant chunk first, and chains the carry through a register. It presents the W-bit result with carry-out and signed overflow through a second valid/ready handshake.

## Interface
- W, default 128: operand/result width; must be a multiple of N.
- N, default 32: chunk width processed per cycle; must be a multiple of 8 and at least 16.
- CHUNKS, derived = W/N: cycles per operation; must be at least 2.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry-in for add; ignored when op_sub=1.
- op_sub  input  1  0: A+B+cin; 1: A-B (A + ~B + 1).
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts result.
- sum  output  W  result.
- cout  output  1  carry out of bit W-1 (for subtract: 1 = no borrow).
- overflow  output  1  two's-complement overflow, carry(W-1) XOR carry(W).

## Operation
- The state machine has three states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture:
  - a_reg=a;
  - b_reg = op_sub ? ~b : b;
  - carry_reg = op_sub ? 1 : cin;
  - idx=0.
  - Then go to RUN.
- RUN: the chunk adder gets a_reg[idx*N +: N], b_reg[idx*N +: N], and carry_reg. Each cycle:
  - write sum_reg[idx*N +: N];
  - carry_reg <= chunk cout;
  - idx <= idx+1.
  - When idx==CHUNKS-1, also latch cout and overflow from the chunk adder, then go to DONE.
- DONE: out_valid=1, and sum/cout/overflow are stable. On out_ready, go to IDLE.
- in_valid in RUN or DONE is ignored; the operands are not sampled.
- Modular arithmetic: sum = (A ± B (+cin)) mod 2^W. No saturation.
- Only the final chunk's overflow is reported. Intermediate chunk overflow flags are discarded.
- Upper sum chunks not yet written in RUN hold their previous value. sum is only meaningful while out_valid=1.

## Timing
- Reset values:
  - in_ready=1 (state IDLE);
  - out_valid=0;
  - sum=0, cout=0, overflow=0;
  - idx=0, carry_reg=0.
- Accept at rising edge E0. RUN occupies edges E1..E(CHUNKS); out_valid rises after edge E(CHUNKS).
  - Latency is CHUNKS cycles from accept to out_valid. For W=128, N=32, that is 4 cycles.
- If out_ready is already high when out_valid rises, the result is consumed on the next edge. in_ready returns 1 in the following cycle.
  - Minimum issue interval is CHUNKS+2 cycles.
- out_valid with out_ready low: state, outputs, and in_ready=0 are held indefinitely.
- The chunk adder path is combinational within one cycle: from the operand/carry registers through the adder to sum_reg and carry_reg.
- rst_n low at any time, including mid-RUN or in DONE: immediate return to IDLE with all reset values. The in-flight operation is discarded and no out_valid pulse occurs.

## Structure
- Shared package: W/N defaults and the state enum encoding (IDLE=0, RUN=1, DONE=2).
- One sub-module: chunk_adder.
  - N-bit ripple adder with a true carry-in.
  - Outputs sum, cout, and overflow = C[N-1]^C[N].
  - Purely combinational, instantiated once.
- idx counter width: $clog2(CHUNKS).

## Test plan
- Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, sum=0, cout=0, overflow=0.
- Add with chunk carry propagation: a=0xFFFF_FFFF, b=1, cin=0, op_sub=0 -> sum=0x1_0000_0000, cout=0, overflow=0. out_valid is high exactly 4 cycles after accept.
- Full wrap: a=all ones, b=0, cin=1 -> sum=0, cout=1, overflow=0. Every chunk propagates the carry.
- Signed overflow: a=0x7FFF…FFFF, b=1, cin=0 -> sum=0x8000…0000, overflow=1, cout=0.
- Subtract: a=5, b=7, op_sub=1, cin=1 (ignored) -> sum=0xFFFF…FFFE, cout=0, overflow=0. Second case a=7, b=5 -> sum=2, cout=1.
- Backpressure and reset:
  - out_ready=0 for 5 cycles -> outputs stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 -> IDLE next cycle.
  - rst_n pulsed low at RUN idx=2 -> IDLE, out_valid never asserted. A new operation then completes correctly.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared parameters and state encoding for the multi-cycle wide adder/subtractor.
package multiword_add_seq_pkg;

  localparam int W_DEFAULT = 128;
  localparam int N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_chunk_adder.sv
// N-bit ripple adder with true carry-in; reports carry-out and signed overflow of its MSB.
module multiword_add_seq_chunk_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  logic carry;
  logic carry_msb;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sum       = '0;
    carry     = cin;
    carry_msb = 1'b0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      if (i == N - 1) carry_msb = carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout     = carry;
    overflow = carry_msb ^ carry;
  end

endmodule

// File: rtl/multiword_add_seq.sv
// Wide A+B+cin / A-B computed one N-bit chunk per cycle, LS chunk first, with the
// carry chained through a register; valid/ready on both operand and result sides.
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int CHUNKS = W / N;
  localparam int IDX_W  = $clog2(CHUNKS);

  state_t state, state_next;

  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IDX_W-1:0] idx;

  logic             accept;
  logic             step;
  logic             last;

  logic [N-1:0]     chunk_a;
  logic [N-1:0]     chunk_b;
  logic [N-1:0]     chunk_sum;
  logic             chunk_cout;
  logic             chunk_ovf;

  assign last    = (idx == IDX_W'(CHUNKS - 1));
  assign chunk_a = a_reg[idx*N +: N];
  assign chunk_b = b_reg[idx*N +: N];

  multiword_add_seq_chunk_adder #(.N(N)) u_chunk_adder (
    .a        (chunk_a),
    .b        (chunk_b),
    .cin      (carry_reg),
    .sum      (chunk_sum),
    .cout     (chunk_cout),
    .overflow (chunk_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Subtraction is folded in at capture: B is inverted and the initial carry forced to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      a_reg     <= a;
      b_reg     <= op_sub ? ~b : b;
      carry_reg <= op_sub ? 1'b1 : cin;
      idx       <= '0;
    end else if (step) begin
      sum_reg[idx*N +: N] <= chunk_sum;
      carry_reg           <= chunk_cout;
      idx                 <= idx + 1'b1;
      if (last) begin
        cout_reg <= chunk_cout;
        ovf_reg  <= chunk_ovf;
      end
    end
  end

  assign sum      = sum_reg;
  assign cout     = cout_reg;
  assign overflow = ovf_reg;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq: directed and random operations, backpressure,
// and a reset in the middle of RUN.
module tb_multiword_add_seq;

  localparam int W      = 128;
  localparam int N      = 32;
  localparam int CHUNKS = W / N;
  localparam int TMO    = 20;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  multiword_add_seq #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width arithmetic; overflow from operand/result sign relationship.
  function automatic exp_t model(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                                 input logic c, input logic s);
    logic [W:0]   full;
    logic [W-1:0] bb;
    exp_t         e;
    bb     = s ? ~op_b : op_b;
    full   = {1'b0, op_a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (op_a[W-1] == bb[W-1]) && (full[W-1] != op_a[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_wide();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                       input logic c, input logic s, input int stall, input string tag);
    exp_t e;
    int   lat;
    lat = 0;
    while (!in_ready && lat < TMO) begin
      tick();
      lat++;
    end
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    a        = op_a;
    b        = op_b;
    cin      = c;
    op_sub   = s;
    in_valid = 1'b1;
    sb.push_back(model(op_a, op_b, c, s));
    tick();
    in_valid = 1'b0;
    a        = ~op_a;
    b        = ~op_b;
    op_sub   = ~s;
    lat = 0;
    while (!out_valid && lat < TMO) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, W'(lat), W'(CHUNKS));
    e = sb.pop_front();
    if (out_valid) begin
      for (int k = 0; k < stall; k++) begin
        check({tag, "_stall_valid"}, W'(out_valid), W'(1));
        check({tag, "_stall_ready"}, W'(in_ready), W'(0));
        check({tag, "_stall_sum"}, sum, e.sum);
        in_valid = 1'b1;
        a        = rand_wide();
        b        = rand_wide();
        tick();
      end
      in_valid = 1'b0;
      check({tag, "_sum"}, sum, e.sum);
      check({tag, "_cout"}, W'(cout), W'(e.cout));
      check({tag, "_ovf"}, W'(overflow), W'(e.ovf));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_idle_valid"}, W'(out_valid), W'(0));
      check({tag, "_idle_ready"}, W'(in_ready), W'(1));
    end
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] smax;
    logic         seen;
    ones      = '1;
    smax      = {1'b0, {(W-1){1'b1}}};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    op_sub    = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum", sum, '0);
    check("rst_cout", W'(cout), W'(0));
    check("rst_ovf", W'(overflow), W'(0));

    do_op(W'(32'hFFFF_FFFF), W'(1), 1'b0, 1'b0, 0, "chunk_carry");
    do_op(ones, '0, 1'b1, 1'b0, 0, "full_wrap");
    do_op(smax, W'(1), 1'b0, 1'b0, 0, "signed_ovf");
    do_op(W'(5), W'(7), 1'b1, 1'b1, 0, "sub_5_7");
    do_op(W'(7), W'(5), 1'b1, 1'b1, 0, "sub_7_5");
    do_op(rand_wide(), rand_wide(), 1'b1, 1'b0, 5, "backpressure");

    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= out_valid;
      tick();
    end
    check("no_spurious_op", W'(seen), W'(0));

    // Abort an operation once idx has reached 2.
    a        = rand_wide();
    b        = rand_wide();
    cin      = 1'b1;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("mid_run_busy", W'(in_ready), W'(0));
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", W'(in_ready), W'(1));
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_sum", sum, '0);
    check("abort_cout", W'(cout), W'(0));
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen |= out_valid;
      tick();
    end
    check("abort_no_valid", W'(seen), W'(0));
    do_op(W'(32'h1234_5678), smax, 1'b1, 1'b0, 0, "after_abort");

    for (int i = 0; i < 6; i++) begin
      do_op(rand_wide(), rand_wide(), 1'($urandom), 1'(i % 2), 0, "random");
    end

    check("scoreboard_empty", W'(sb.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
